pwm_decoder: RTL and testbench

Audio PWM capture block: recovers the per-frame duty-cycle threshold from a PWM waveform generated by the team's PWM output controller, which counts 0..max and drives high while count < threshold. Samples the asynchronous input, locks onto rising edges, counts high cycles per frame of max+1 cycles and presents each count as a w-bit sample on a valid/ready interface. Used for loopback verification of the sound path and for capturing an external PWM source.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_decoder_if.sv | 33 +++
 rtl/pwm_sync.sv | 69 ++++++
 rtl/pwm_decoder.sv | 111 +++++++++++
 tb/tb_pwm_decoder.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared PWM constants, decoder FSM state type and a majority helper.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int               PWM_W   = 11;
    localparam logic [PWM_W-1:0] PWM_MAX = 11'd1042;

    typedef enum logic [0:0] {
        ACQ = 1'b0,
        RUN = 1'b1
    } pwm_dec_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder_if
// Purpose  : Sample valid/ready channel of the PWM decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_decoder_if
    import pwm_pkg::*;
#(
    parameter int W = PWM_W
);

    logic [W-1:0] sample;
    logic         sample_valid;
    logic         sample_ready;
    logic         period_err;

    modport master (
        output sample,
        output sample_valid,
        output period_err,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        input  period_err,
        output sample_ready
    );

endinterface
`default_nettype wire

// File: rtl/pwm_sync.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sync
// Purpose  : 2-flop synchronizer, optional majority glitch filter
//            (PWM_DECODER_FILTER_EN) and rising-edge detect for pwm_in.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_pwm_in,
    output logic o_s,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_s_d;
    logic w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_DECODER_FILTER_EN
    // Majority of the last three synchronized samples: single-cycle
    // pulses or drops never reach two votes, both edges shift by 2 cycles.
    logic r_hist1;
    logic r_hist2;
    logic r_maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
            r_maj   <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
            r_maj   <= maj3(r_sync2, r_hist1, r_hist2);
        end
    end

    assign w_s = r_maj;
`else
    assign w_s = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign o_s    = w_s;
    assign o_rise = w_s & ~r_s_d;

endmodule
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder
// Purpose  : Recovers per-frame PWM high-cycle count and publishes it on a
//            valid/ready channel. Build option: PWM_DECODER_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int           W   = PWM_W,
    parameter logic [W-1:0] MAX = PWM_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pwm_in,
    pwm_decoder_if.master bus,
    output logic          o_overrun,
    output logic          o_locked
);

    localparam logic [W-1:0] c_FRAME_LEN = MAX + W'(1);

    logic           w_s;
    logic           w_rise;
    logic           w_frame_full;
    logic           w_close;
    logic           w_publish;

    logic [W-1:0]   r_fr_cnt;
    logic [W-1:0]   r_hi_cnt;

    pwm_dec_state_t r_state;
    pwm_dec_state_t w_state_nxt;

    logic [W-1:0]   r_sample;
    logic           r_valid;
    logic           r_period_err;
    logic           r_overrun;

    pwm_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pwm_in (i_pwm_in),
        .o_s      (w_s),
        .o_rise   (w_rise)
    );

    // A rise landing exactly on the frame timeout is one close, not two.
    assign w_frame_full = (r_fr_cnt == c_FRAME_LEN);
    assign w_close      = w_rise | w_frame_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fr_cnt <= '0;
            r_hi_cnt <= '0;
        end else if (w_close) begin
            r_fr_cnt <= W'(1);
            r_hi_cnt <= W'(w_s);
        end else begin
            r_fr_cnt <= r_fr_cnt + W'(1);
            r_hi_cnt <= r_hi_cnt + W'(w_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The first close only establishes frame phase; its partial count is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        case (r_state)
            ACQ:     if (w_close) w_state_nxt = RUN;
            RUN:     w_publish = w_close;
            default: w_state_nxt = ACQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_period_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_publish) begin
                r_sample     <= r_hi_cnt;
                r_period_err <= ~w_frame_full;
                r_valid      <= 1'b1;
                r_overrun    <= r_valid & ~bus.sample_ready;
            end else if (r_valid && bus.sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.period_err   = r_period_err;
    assign o_overrun        = r_overrun;
    assign o_locked         = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_decoder
// Purpose  : Scoreboard bench for pwm_decoder driven by an encoder-style source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_decoder;
    import pwm_pkg::*;

    localparam int FL = 1043;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwm   = 1'b0;
    logic ready = 1'b0;
    logic overrun;
    logic locked;

    pwm_decoder_if bus ();
    assign bus.sample_ready = ready;

    pwm_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pwm_in  (pwm),
        .bus       (bus),
        .o_overrun (overrun),
        .o_locked  (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] s;
        logic        perr;
        logic        drop;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input bit perr, input bit drop);
        exp_t e;
        e.s    = 11'(s);
        e.perr = perr;
        e.drop = drop;
        q.push_back(e);
    endtask

    // Encoder-style source: high while frame position < thr, plus an optional one-cycle glitch.
    task automatic drive(input int thr, input int c0, input int c1, input int glitch_at, input int ready_at);
        for (int c = c0; c < c1; c++) begin
            pwm = (c < thr) || (c == glitch_at);
            if (c == ready_at) ready = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic frame(input int thr, input int len);
        drive(thr, 0, len, -1, -1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (overrun === 1'b1) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL overrun: unexpected pulse with empty queue at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        check("overrun_expected", 1, e.drop);
                    end
                end
                if (bus.sample_valid === 1'b1 && ready === 1'b1) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_sample: got %0d expected none at %0t", bus.sample, $time);
                    end else begin
                        e = q.pop_front();
                        check("accepted_not_dropped", 0, e.drop);
                        check("sample", bus.sample, e.s);
                        check("period_err", bus.period_err, e.perr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", bus.sample, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_period_err", bus.period_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_locked", locked, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Steady threshold 500
        push(500, 0, 0); frame(500, FL);
        check("locked_after_first_frame", locked, 1);
        push(500, 0, 0); frame(500, FL);
        push(500, 0, 0); frame(500, FL);

        // Constant low, constant high, back to 500
        push(0, 0, 0);    frame(0, FL);
        push(0, 0, 0);    frame(0, FL);
        push(1043, 0, 0); frame(1043, FL);
        push(1043, 0, 0); frame(1043, FL);
        push(500, 0, 0);  frame(500, FL);
        check("locked_held", locked, 1);

        // Early rise after 600 cycles
        push(500, 1, 0); frame(500, 600);
        push(500, 0, 0); frame(500, FL);

        // Back-pressure: 300 is overwritten by 700
        push(200, 0, 0); frame(200, FL);
        push(300, 0, 1); drive(300, 0, FL, -1, 100);
        push(700, 0, 0); frame(700, FL);
        push(400, 0, 0); drive(400, 0, 100, -1, -1);
        check("held_valid", bus.sample_valid, 1);
        check("held_sample", bus.sample, 700);
        ready = 1'b1;
        @(posedge clk); #1;
        check("valid_after_accept", bus.sample_valid, 0);
        drive(400, 101, FL, -1, -1);

        // Single-cycle glitch at frame position 800
`ifdef PWM_DECODER_FILTER_EN
        push(400, 0, 0);
`else
        push(400, 1, 0);
        push(1, 1, 0);
`endif
        drive(400, 0, FL, 800, -1);
        push(400, 0, 0); frame(400, FL);

        drive(250, 0, 20, -1, -1);
        drain("drain_main");
        mon_en = 1'b0;
        pwm    = 1'b0;

        // Mid-frame reset with a pending sample
        ready = 1'b0;
        n = 0;
        while (bus.sample_valid !== 1'b1 && n < 1500) begin
            @(posedge clk); #1;
            n++;
        end
        check("pending_before_reset", bus.sample_valid, 1);
        repeat (37) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_sample", bus.sample, 0);
        check("async_rst_valid", bus.sample_valid, 0);
        check("async_rst_period_err", bus.period_err, 0);
        check("async_rst_overrun", overrun, 0);
        check("async_rst_locked", locked, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ready  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("unlocked_before_rise", locked, 0);
        push(600, 0, 0);
        drive(600, 0, 12, -1, -1);
        check("locked_after_rise", locked, 1);
        drive(600, 12, FL, -1, -1);
        push(700, 0, 0); frame(700, FL);
        drive(250, 0, 20, -1, -1);
        drain("drain_after_reset");
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
